// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: two-channel round-robin arbiter driving a transmission-gate
// 2:1 mux. A dead cycle separates any change of enabled gate so the two gates
// are never on together. The selected beat is registered into a valid/ready
// output stage.
module mux_sel_arbiter #(
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic         ack0,
  output logic         ack1,
  output logic         en0,
  output logic         en1,
  output logic         sel,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    DEAD   = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic          last, last_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          sel_nx;

  logic          can_load;
  logic          any_req;
  logic          pick;
  logic          own_req;
  logic          own_ack;
  logic          other_req;
  logic          burst_end;

  // Output stage can take a new beat when empty or draining this cycle.
  assign can_load = !out_valid || out_ready;

  // Gate enables and accepts come straight from the registered state.
  assign en0  = (state == GRANT0);
  assign en1  = (state == GRANT1);
  assign ack0 = en0 && req0 && can_load;
  assign ack1 = en1 && req1 && can_load;

  assign any_req   = req0 || req1;
  // On a tie the channel that was not granted last wins.
  assign pick      = (req0 && req1) ? ~last : req1;
  assign burst_end = (cnt == CW'(MAX_BURST - 1));

  // View of the currently granted channel versus the other one.
  always_comb begin
    own_req   = 1'b0;
    own_ack   = 1'b0;
    other_req = 1'b0;
    if (state == GRANT0) begin
      own_req   = req0;
      own_ack   = ack0;
      other_req = req1;
    end else if (state == GRANT1) begin
      own_req   = req1;
      own_ack   = ack1;
      other_req = req0;
    end
  end

  // Next-state, round-robin pointer and burst counter.
  always_comb begin
    state_nx = state;
    last_nx  = last;
    cnt_nx   = cnt;
    case (state)
      IDLE, DEAD: begin
        if (any_req) begin
          state_nx = pick ? GRANT1 : GRANT0;
          last_nx  = pick;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        if (!own_req) begin
          state_nx = DEAD;
        end else if (own_ack) begin
          if (burst_end) begin
            // Full burst: yield only if the other side is waiting, otherwise
            // start a fresh burst without a dead cycle.
            cnt_nx = '0;
            if (other_req) begin
              state_nx = DEAD;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // sel follows the granted channel and holds through IDLE and DEAD.
  always_comb begin
    sel_nx = sel;
    if (state_nx == GRANT1) begin
      sel_nx = 1'b1;
    end else if (state_nx == GRANT0) begin
      sel_nx = 1'b0;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      sel   <= 1'b0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
      sel   <= sel_nx;
    end
  end

  // Output register: an accepted beat replaces the held one; otherwise a
  // consumed beat empties the stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ack0) begin
      out_valid <= 1'b1;
      out_data  <= d0;
    end else if (ack1) begin
      out_valid <= 1'b1;
      out_data  <= d1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Gates must never overlap and grants never hand over without a dead cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(en0 && en1));
      assert (!((state == GRANT0 && state_nx == GRANT1) ||
                (state == GRANT1 && state_nx == GRANT0)));
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed stimulus with a scoreboard of expected output
// beats; a negedge monitor pops and compares every handshake.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] d0, d1;
  logic       ack0, ack1;
  logic       en0, en1;
  logic       sel;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  mux_sel_arbiter #(.W(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .d0        (d0),
    .d1        (d1),
    .ack0      (ack0),
    .ack1      (ack1),
    .en0       (en0),
    .en1       (en1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, req, $time);
    end
  endtask

  // Settle combinational outputs, then compare gate enables and accepts.
  task automatic expect_io(input string tag, input logic e0, input logic e1,
                           input logic a0, input logic a1);
    #1;
    check1({tag, "_en0"}, en0, e0);
    check1({tag, "_en1"}, en1, e1);
    check1({tag, "_ack0"}, ack0, a0);
    check1({tag, "_ack1"}, ack1, a1);
  endtask

  // Advance one cycle; each source moves to its next beat when accepted.
  task automatic step();
    logic a0, a1;
    a0 = ack0;
    a1 = ack1;
    @(posedge clk);
    #1;
    if (a0 === 1'b1) d0 = d0 + 8'd1;
    if (a1 === 1'b1) d1 = d1 + 8'd1;
  endtask

  // Scoreboard monitor: every handshake must match the next expected beat.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check1("gate_overlap", en0 & en1, 1'b0);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got 0x%02h expected none at %0t", out_data, $time);
        end else begin
          check8("beat", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req0      = 1'b1;
    req1      = 1'b1;
    d0        = 8'h01;
    d1        = 8'h11;
    out_ready = 1'b1;

    // Reset held for three cycles with both channels requesting.
    repeat (3) @(posedge clk);
    #1;
    expect_io("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check1("rst_valid", out_valid, 1'b0);
    check1("rst_sel", sel, 1'b0);
    check8("rst_data", out_data, 8'h00);

    // Contention: 4 beats ch0, dead, 4 beats ch1, dead, repeating.
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13); exp_q.push_back(8'h14);
    exp_q.push_back(8'h05); exp_q.push_back(8'h06); exp_q.push_back(8'h07); exp_q.push_back(8'h08);
    exp_q.push_back(8'h15); exp_q.push_back(8'h16); exp_q.push_back(8'h17); exp_q.push_back(8'h18);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      int p;
      p = i % 10;
      if (i == 19) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      expect_io("cont", p < 4, (p >= 5) && (p < 9), p < 4, (p >= 5) && (p < 9));
      check1("cont_sel", sel, p >= 5);
      step();
    end

    // Single-channel stream on ch1: no dead cycles, one beat per cycle.
    req1 = 1'b1;
    d1   = 8'h21;
    for (int k = 0; k < 10; k++) exp_q.push_back(8'(8'h21 + k));
    expect_io("s2_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check1("s2_idle_sel", sel, 1'b1);
    step();
    for (int k = 0; k < 10; k++) begin
      expect_io("s2_stream", 1'b0, 1'b1, 1'b0, 1'b1);
      check1("s2_sel", sel, 1'b1);
      if (k > 0) check8("s2_data", out_data, 8'(8'h20 + k));
      step();
    end
    req1 = 1'b0;
    expect_io("s2_drop", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    expect_io("s2_dead", 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Backpressure mid-burst: stalled cycles do not count toward the burst.
    req0 = 1'b1;
    req1 = 1'b1;
    d0   = 8'h31;
    exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h33); exp_q.push_back(8'h34);
    expect_io("s3_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    expect_io("s3_b0", 1'b1, 1'b0, 1'b1, 1'b0);
    check1("s3_sel", sel, 1'b0);
    step();
    expect_io("s3_b1", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    for (int s = 0; s < 5; s++) begin
      out_ready = 1'b0;
      expect_io("s3_stall", 1'b1, 1'b0, 1'b0, 1'b0);
      check1("s3_stall_valid", out_valid, 1'b1);
      check8("s3_stall_data", out_data, 8'h32);
      step();
    end
    out_ready = 1'b1;
    expect_io("s3_b2", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    expect_io("s3_b3", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    req0 = 1'b0;
    req1 = 1'b0;
    expect_io("s3_dead", 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Requester drops mid-burst, then reset lands during the ch1 grant.
    req0 = 1'b1;
    req1 = 1'b0;
    d0   = 8'h41;
    d1   = 8'h51;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h51);
    expect_io("s4_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    req1 = 1'b1;
    expect_io("s4_b0", 1'b1, 1'b0, 1'b1, 1'b0);
    check1("s4_sel_g0", sel, 1'b0);
    step();
    expect_io("s4_b1", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    req0 = 1'b0;
    expect_io("s4_drop", 1'b1, 1'b0, 1'b0, 1'b0);
    check1("s4_sel_drop", sel, 1'b0);
    step();
    expect_io("s4_dead", 1'b0, 1'b0, 1'b0, 1'b0);
    check1("s4_sel_dead", sel, 1'b0);
    step();
    expect_io("s4_g1a", 1'b0, 1'b1, 1'b0, 1'b1);
    check1("s4_sel_g1", sel, 1'b1);
    step();
    expect_io("s4_g1b", 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    out_ready = 1'b0;
    rst_n     = 1'b0;
    expect_io("s4_prerst", 1'b0, 1'b1, 1'b0, 1'b0);
    check1("s4_prerst_valid", out_valid, 1'b1);
    check8("s4_prerst_data", out_data, 8'h52);
    step();
    rst_n     = 1'b1;
    req0      = 1'b1;
    req1      = 1'b1;
    d0        = 8'h61;
    out_ready = 1'b1;
    exp_q.push_back(8'h61);
    expect_io("s5_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check1("s5_rst_valid", out_valid, 1'b0);
    check8("s5_rst_data", out_data, 8'h00);
    check1("s5_rst_sel", sel, 1'b0);
    step();
    expect_io("s5_first", 1'b1, 1'b0, 1'b1, 1'b0);
    check1("s5_first_valid", out_valid, 1'b0);
    step();
    req0 = 1'b0;
    req1 = 1'b0;
    expect_io("s5_lat", 1'b1, 1'b0, 1'b0, 1'b0);
    check1("s5_lat_valid", out_valid, 1'b1);
    check8("s5_lat_data", out_data, 8'h61);
    step();
    expect_io("s5_dead", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drained: got %0d beats pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
